// File: rtl/snn_pkg.sv
// snn_pkg
//   Shared definitions for the SNN datapath: default layer geometry used by
//   the neuron layer and the output decoder, and the decoder FSM state type.
//   No ports (package).
package snn_pkg;

  // Default output-layer geometry, shared with the neuron layer.
  localparam int SNN_N_CH   = 10;
  localparam int SNN_IDX_W  = 4;
  localparam int SNN_CNT_W  = 8;

  // Window tick counter width; covers window lengths up to 65535 ticks.
  localparam int SNN_TICK_W = 16;

  // Decoder FSM: IDLE -> ACCUM -> SCAN -> DONE -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } dec_state_t;

endpackage

// File: rtl/spike_sat_counter.sv
// spike_sat_counter
//   One per-channel spike counter. Synchronous clear has priority over
//   increment; the count holds at all-ones instead of wrapping.
// Ports:
//   clk  in           clock
//   rst  in           asynchronous active-high reset
//   clr  in           synchronous clear
//   inc  in           count one spike this cycle
//   cnt  out [CNT_W]  current count
module spike_sat_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = SNN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Output-side decoder for the SNN datapath. Counts spikes per channel over
//   a window of WIN timestep ticks, then scans the counts one channel per
//   cycle and reports the argmax channel and its count.
//
//   Optional build macro: SPK_DECODE_THRESH_EN
//     defined   : winner_valid = (winner_cnt >= THRESH) at DONE
//     undefined : winner_valid = 1 at every DONE, no comparator built
//
// Ports:
//   clk           in              clock
//   rst           in              asynchronous active-high reset
//   start         in              begin a decode window (IDLE only)
//   tick          in              timestep strobe, qualifies spk_in
//   spk_in        in  [N_CH]      spike vector, bit i = channel i
//   rd_idx        in  [IDX_W]     count read-back index
//   rd_cnt        out [CNT_W]     combinational count of rd_idx (0 if out of range)
//   busy          out             high in ACCUM and SCAN
//   done          out             one-cycle pulse, result valid
//   winner        out [IDX_W]     argmax channel, held
//   winner_cnt    out [CNT_W]     count of winner, held
//   winner_valid  out             decision-quality flag, held
//
// Handshake: start is a level sampled on each rising edge; it is accepted
// only while the FSM is in IDLE (busy=0, done=0). A start seen in any other
// state is dropped, not remembered. The result outputs are valid from the
// cycle done=1 until the next accepted start clears them.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_CH   = SNN_N_CH,
  parameter int IDX_W  = SNN_IDX_W,
  parameter int CNT_W  = SNN_CNT_W,
  parameter int WIN    = 256,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tick,
  input  logic [N_CH-1:0]  spk_in,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] winner,
  output logic [CNT_W-1:0] winner_cnt,
  output logic             winner_valid
);

  // Elaboration-time parameter sanity checks.
  if ((1 << IDX_W) < N_CH) begin : g_chk_idx_w
    $error("spike_rate_decoder: IDX_W too narrow for N_CH");
  end
  if ((WIN < 1) || (WIN > 65535)) begin : g_chk_win
    $error("spike_rate_decoder: WIN out of range 1..65535");
  end
  if (THRESH < 0) begin : g_chk_thresh
    $error("spike_rate_decoder: THRESH must be non-negative");
  end

  localparam logic [SNN_TICK_W-1:0] TICK_LAST = SNN_TICK_W'(WIN - 1);
  localparam logic [IDX_W-1:0]      SCAN_LAST = IDX_W'(N_CH - 1);

  dec_state_t             state;
  dec_state_t             state_nx;
  logic [SNN_TICK_W-1:0]  tick_cnt;
  logic [CNT_W-1:0]       cnt [N_CH];
  logic [N_CH-1:0]        cnt_inc;
  logic                   cnt_clr;
  logic                   accept_start;
  logic                   last_tick;
  logic                   last_scan;

  logic [IDX_W-1:0]       scan_idx;
  logic [IDX_W-1:0]       best_idx;
  logic [CNT_W-1:0]       best_cnt;
  logic [CNT_W-1:0]       scan_cnt;
  logic                   cand_take;
  logic [IDX_W-1:0]       final_idx;
  logic [CNT_W-1:0]       final_cnt;
  logic                   final_valid;

  // ---------------------------------------------------------------------
  // Per-channel saturating counters
  // ---------------------------------------------------------------------
  assign accept_start = (state == ST_IDLE) && start;
  assign cnt_clr      = accept_start;
  assign cnt_inc      = ((state == ST_ACCUM) && tick) ? spk_in : '0;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    spike_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .inc(cnt_inc[g]),
      .cnt(cnt[g])
    );
  end

  // Read-back mux; indices at or beyond N_CH read as zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_idx == IDX_W'(i)) rd_cnt = cnt[i];
    end
  end

  // ---------------------------------------------------------------------
  // Argmax scan: one channel per cycle, strict > keeps the lowest index
  // on ties. final_* is the best after including the current channel.
  // ---------------------------------------------------------------------
  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (scan_idx == IDX_W'(i)) scan_cnt = cnt[i];
    end
  end

  assign cand_take = (scan_cnt > best_cnt);
  assign final_idx = cand_take ? scan_idx : best_idx;
  assign final_cnt = cand_take ? scan_cnt : best_cnt;

`ifdef SPK_DECODE_THRESH_EN
  localparam logic [31:0] THRESH_U = 32'(THRESH);
  assign final_valid = (32'(final_cnt) >= THRESH_U);
`else
  assign final_valid = 1'b1;
`endif

  assign last_tick = (state == ST_ACCUM) && tick && (tick_cnt == TICK_LAST);
  assign last_scan = (state == ST_SCAN) && (scan_idx == SCAN_LAST);

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)     state_nx = ST_ACCUM;
      ST_ACCUM: if (last_tick) state_nx = ST_SCAN;
      ST_SCAN:  if (last_scan) state_nx = ST_DONE;
      ST_DONE:                 state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State register, window/scan bookkeeping and registered outputs.
  // busy/done are registered from the next state so they line up with the
  // state they describe.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= '0;
      winner_cnt   <= '0;
      winner_valid <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ST_ACCUM) || (state_nx == ST_SCAN);
      done  <= (state_nx == ST_DONE);

      if (accept_start || last_tick) begin
        tick_cnt <= '0;
      end else if ((state == ST_ACCUM) && tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (last_tick) begin
        scan_idx <= '0;
        best_idx <= '0;
        best_cnt <= '0;
      end else if (state == ST_SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        best_idx <= final_idx;
        best_cnt <= final_cnt;
      end

      if (accept_start) begin
        winner       <= '0;
        winner_cnt   <= '0;
        winner_valid <= 1'b0;
      end else if (last_scan) begin
        winner       <= final_idx;
        winner_cnt   <= final_cnt;
        winner_valid <= final_valid;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder
//   Self-checking bench for spike_rate_decoder. Two instances: a main one
//   (N_CH=10, CNT_W=8, WIN=16) and a narrow-counter one (CNT_W=4, WIN=32)
//   for saturation. Expected results come from per-channel spike totals
//   kept by the bench, clamped to the counter maximum, and an argmax with
//   lowest-index tie-break. Honours SPK_DECODE_THRESH_EN like the design.
module tb_spike_rate_decoder;

  localparam int N_CH    = 10;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 8;
  localparam int WIN     = 16;
  localparam int THRESH  = 4;
  localparam int S_CNT_W = 4;
  localparam int S_WIN   = 32;
  localparam int MAX_CYC = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic             start  = 1'b0;
  logic             tick   = 1'b0;
  logic [N_CH-1:0]  spk_in = '0;
  logic [IDX_W-1:0] rd_idx = '0;
  logic [CNT_W-1:0] rd_cnt;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] winner_cnt;
  logic             winner_valid;

  // saturation instance
  logic               s_start  = 1'b0;
  logic               s_tick   = 1'b0;
  logic [N_CH-1:0]    s_spk_in = '0;
  logic [IDX_W-1:0]   s_rd_idx = '0;
  logic [S_CNT_W-1:0] s_rd_cnt;
  logic               s_busy;
  logic               s_done;
  logic [IDX_W-1:0]   s_winner;
  logic [S_CNT_W-1:0] s_winner_cnt;
  logic               s_winner_valid;

  spike_rate_decoder #(
    .N_CH(N_CH), .IDX_W(IDX_W), .CNT_W(CNT_W), .WIN(WIN), .THRESH(THRESH)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .spk_in(spk_in),
    .rd_idx(rd_idx), .rd_cnt(rd_cnt), .busy(busy), .done(done),
    .winner(winner), .winner_cnt(winner_cnt), .winner_valid(winner_valid)
  );

  spike_rate_decoder #(
    .N_CH(N_CH), .IDX_W(IDX_W), .CNT_W(S_CNT_W), .WIN(S_WIN), .THRESH(THRESH)
  ) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .tick(s_tick), .spk_in(s_spk_in),
    .rd_idx(s_rd_idx), .rd_cnt(s_rd_cnt), .busy(s_busy), .done(s_done),
    .winner(s_winner), .winner_cnt(s_winner_cnt), .winner_valid(s_winner_valid)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          m_cnt[N_CH];   // raw spike totals of the current window

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int c, input int maxv);
    return (c > maxv) ? maxv : c;
  endfunction

  // Argmax of clamped totals, lowest index wins ties; pushes winner,
  // count and validity onto the expected queue.
  task automatic push_expected(input int maxv);
    int w, wc;
    bit wv;
    w  = 0;
    wc = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (clamp(m_cnt[i], maxv) > wc) begin
        w  = i;
        wc = clamp(m_cnt[i], maxv);
      end
    end
`ifdef SPK_DECODE_THRESH_EN
    wv = (wc >= THRESH);
`else
    wv = 1'b1;
`endif
    exp_q.push_back(32'(w));
    exp_q.push_back(32'(wc));
    exp_q.push_back(32'(wv));
  endtask

  // Spike pattern for a given window mode and tick number.
  function automatic logic [N_CH-1:0] gen_spk(input int mode, input int t, input logic [N_CH-1:0] r);
    logic [N_CH-1:0] s;
    s = '0;
    case (mode)
      0: s[3] = 1'b1;
      1: begin s[2] = (t < 5); s[7] = (t < 5); s[5] = (t < 4); end
      2: s = r;
      3: begin s[4] = (t < 3); s[6] = (t < 2); end
      4: s = '0;
      5: s = r & N_CH'($urandom) & N_CH'($urandom);
      6: s[1] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sweep_rd(input string tag, input int maxv);
    for (int k = 0; k < (1 << IDX_W); k++) begin
      rd_idx = IDX_W'(k);
      #1;
      check_eq(tag, rd_cnt, (k < N_CH) ? clamp(m_cnt[k], maxv) : 0);
    end
  endtask

  // One window on the main instance. tper: tick every tper-th cycle;
  // mid_start: pulse start again during ACCUM.
  task automatic run_window(input int mode, input int tper, input bit mid_start);
    int cyc, ticks, last_tick_cyc;
    bit seen;
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    @(negedge clk);
    start  = 1'b1;
    tick   = 1'b0;
    spk_in = N_CH'($urandom);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; ticks = 0; seen = 1'b0; last_tick_cyc = 0;
    check_eq("busy_rise", busy, 1);
    check_eq("winner_clr", winner, 0);
    check_eq("wcnt_clr", winner_cnt, 0);
    check_eq("wvalid_clr", winner_valid, 0);
    while (!seen && cyc < MAX_CYC) begin
      start = mid_start && (cyc == 7);
      v = N_CH'($urandom);
      if (ticks < WIN) begin
        tick = (((cyc - 1) % tper) == 0);
        if (tick) begin
          spk_in = gen_spk(mode, ticks, v);
          for (int i = 0; i < N_CH; i++) if (spk_in[i]) m_cnt[i]++;
          ticks++;
          if (ticks == WIN) last_tick_cyc = cyc;
        end else begin
          spk_in = v;
        end
      end else begin
        tick   = 1'($urandom_range(0, 1));
        spk_in = v;
      end
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else check_eq("busy_hold", busy, 1);
    end
    start = 1'b0;
    tick  = 1'b0;
    if (!seen) begin
      check_eq("done_timeout", 0, 1);
    end else begin
      push_expected((1 << CNT_W) - 1);
      check_eq("done_latency", cyc, last_tick_cyc + N_CH + 1);
      check_eq("busy_fall", busy, 0);
      check_eq("winner", winner, exp_q.pop_front());
      check_eq("winner_cnt", winner_cnt, exp_q.pop_front());
      check_eq("winner_valid", winner_valid, exp_q.pop_front());
      @(negedge clk);
      check_eq("done_pulse", done, 0);
      check_eq("idle_busy", busy, 0);
      sweep_rd("rd_cnt", (1 << CNT_W) - 1);
    end
  endtask

  // Reset in the middle of ACCUM: everything clears at once, no done.
  task automatic reset_mid();
    bit any_evt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick   = 1'b1;
      spk_in = N_CH'($urandom) | N_CH'(1);
      @(negedge clk);
    end
    tick   = 1'b0;
    rd_idx = '0;
    #1;
    check_eq("pre_rst_cnt0", rd_cnt, 8);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_winner", winner, 0);
    check_eq("rst_wcnt", winner_cnt, 0);
    check_eq("rst_wvalid", winner_valid, 0);
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    sweep_rd("rst_rd_cnt", (1 << CNT_W) - 1);
    @(negedge clk);
    rst = 1'b0;
    any_evt = 1'b0;
    for (int k = 0; k < WIN + N_CH + 4; k++) begin
      tick   = 1'b1;
      spk_in = N_CH'($urandom);
      @(negedge clk);
      if (done || busy) any_evt = 1'b1;
    end
    tick = 1'b0;
    check_eq("no_done_after_rst", any_evt, 0);
  endtask

  // Saturation window on the narrow-counter instance: channel 0 spikes
  // on every tick, other channels sparsely.
  task automatic run_sat();
    int cyc, ticks;
    bit seen;
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 1; ticks = 0; seen = 1'b0;
    check_eq("s_busy_rise", s_busy, 1);
    while (!seen && cyc < MAX_CYC) begin
      s_tick   = 1'b1;
      s_spk_in = (N_CH'($urandom) & N_CH'($urandom)) | N_CH'(1);
      if (ticks < S_WIN) begin
        for (int i = 0; i < N_CH; i++) if (s_spk_in[i]) m_cnt[i]++;
        ticks++;
      end
      @(negedge clk);
      cyc++;
      if (s_done) seen = 1'b1;
    end
    s_tick = 1'b0;
    if (!seen) begin
      check_eq("s_done_timeout", 0, 1);
    end else begin
      push_expected((1 << S_CNT_W) - 1);
      check_eq("s_done_latency", cyc, S_WIN + N_CH + 1);
      check_eq("s_winner", s_winner, exp_q.pop_front());
      check_eq("s_winner_cnt", s_winner_cnt, exp_q.pop_front());
      check_eq("s_winner_valid", s_winner_valid, exp_q.pop_front());
      @(negedge clk);
      for (int k = 0; k < (1 << IDX_W); k++) begin
        s_rd_idx = IDX_W'(k);
        #1;
        check_eq("s_rd_cnt", s_rd_cnt, (k < N_CH) ? clamp(m_cnt[k], (1 << S_CNT_W) - 1) : 0);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_winner", winner, 0);
    check_eq("reset_wcnt", winner_cnt, 0);
    check_eq("reset_wvalid", winner_valid, 0);
    check_eq("reset_rd_cnt", rd_cnt, 0);
    rst = 1'b0;

    run_window(0, 1, 1'b0);   // one-hot channel 3, exact latency
    run_window(1, 1, 1'b0);   // tie 2/7 at 5, channel 5 at 4
    run_window(6, 3, 1'b1);   // sparse ticks, ignored restart
    run_window(3, 1, 1'b0);   // best count 3, below threshold
    run_window(4, 1, 1'b0);   // all-zero window
    reset_mid();
    run_window(2, 1, 1'b0);   // dense random
    for (int k = 0; k < 4; k++) begin
      run_window(5, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
    run_sat();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
